maxpool_relu_3ch: RTL
=====================

Name: maxpool_relu_3ch

Overview:
- Consumes the 3-channel 5x5 convolution output stream (3 x 12-bit signed, one pixel per valid, raster order, 24x24 frame).
- Applies ReLU, then 2x2 max-pooling with stride 2, per channel.
- Emits a 12x12 pooled map per channel to the next layer.
- Sits directly downstream of the first convolution stage.

Parameters:
- WIDTH, 24, conv output columns per row; must be even.
- HEIGHT, 24, conv output rows per frame; must be even.
- DATA_BIT, 12, width of each conv sample and pooled output.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low
- valid_in  input  1  conv_in_1..3 carry one valid pixel this cycle
- conv_in_1  input  DATA_BIT  channel 1 conv result, signed two's complement
- conv_in_2  input  DATA_BIT  channel 2 conv result, signed
- conv_in_3  input  DATA_BIT  channel 3 conv result, signed
- pool_out_1  output  DATA_BIT  channel 1 pooled result
- pool_out_2  output  DATA_BIT  channel 2 pooled result
- pool_out_3  output  DATA_BIT  channel 3 pooled result
- valid_out  output  1  pool_out_1..3 valid this cycle (one-cycle pulse per pooled pixel)
- frame_done  output  1  one-cycle pulse together with the last pooled pixel of a frame

Behaviour:
- Reset (rst=0, asynchronous):
  - col, row counters cleared to 0.
  - pool_out_1..3, valid_out and frame_done cleared to 0.
  - Hold registers cleared to 0. Line buffer is not cleared; every even row overwrites it before it is read.
- Counters:
  - col 0..WIDTH-1 advances only on valid_in=1.
  - At col=WIDTH-1, col wraps to 0 and row increments.
  - At row=HEIGHT-1, col=WIDTH-1, both wrap to 0.
  - valid_in=0 cycles (gaps) freeze all state; arbitrary gaps are allowed.
- Per-channel datapath on an accepted pixel x:
  - r = ReLU(x): 0 if x[DATA_BIT-1]=1, else x.
  - Even col: hold <= r.
  - Odd col: p = max(hold, r), unsigned compare after ReLU.
    - Even row: linebuf[col>>1] <= p.
    - Odd row: pool_out <= max(linebuf[col>>1], p); valid_out <= 1.
- Line buffer: WIDTH/2 entries of DATA_BIT bits per channel; read and write addresses are both col>>1.
- Latency: the pooled pixel appears on the cycle after the accepting edge of its bottom-right input pixel (odd row, odd col). One cycle; no backpressure.
- pool_out holds its last value when valid_out=0.
- frame_done=1 in the same cycle as the valid_out for pooled pixel (HEIGHT/2-1, WIDTH/2-1).
- Per frame: exactly (WIDTH/2)*(HEIGHT/2) valid_out pulses, i.e. 144 at defaults.
- Back-to-back frames: pixel 0 of the next frame may arrive the cycle after the last pixel; no bubble is required.
- Reset mid-frame: the partial frame is discarded; the first pixel after reset is treated as (row 0, col 0).
- All three channels share the counters and are processed in lockstep.

Optional Feature:
- Macro: MAXPOOL_RELU_EN.
- Defined: ReLU is applied as above, and outputs are always non-negative.
- Undefined: ReLU is bypassed. All max comparisons are signed two's complement. Hold and line buffer store raw signed values; pool_out may be negative.

Decomposition:
- Shared package cnn_pkg holds:
  - constants CONV1_OUT_W=24, CONV1_OUT_H=24, CONV_OUT_BIT=12;
  - the pooled dimension constants POOL1_OUT_W/H=12.
- Sub-module maxpool_lane: one channel's ReLU, hold register, line buffer and compare logic. It takes the shared col parity, row parity, address and accept strobe from the top.
- The top instantiates maxpool_lane three times and owns the counters, valid_out and frame_done.

Test Plan:
- Ramp, ch1 pixel value = row*24+col, all positive, continuous valid -> 144 outputs; output (i,j) = (2i+1)*24+2j+1, e.g. (0,0)=25, (11,11)=575; frame_done only with (11,11).
- All pixels -5 (0xFFB) on ch2 -> with MAXPOOL_RELU_EN, all 144 outputs = 0; without it, all = 0xFFB.
- Single spike: ch3 = 100 at (row 6, col 9), else 0 -> exactly one nonzero output, 100 at pooled (3,4), emitted one cycle after pixel (7,9) is accepted.
- Random valid_in gaps (~50% duty) with the ramp stimulus -> results identical to the continuous case; valid_out never asserts during gaps without a preceding odd/odd accept.
- Assert rst low mid-frame at row 13, then send a full frame -> exactly 144 correct outputs for the new frame, no stale outputs, outputs 0 during reset.
- Two back-to-back frames with no gap, second frame = ramp+1 -> second set of outputs = first set +1; two frame_done pulses 144 valids apart.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared CNN geometry constants for the first convolution / pooling stages.
package cnn_pkg;

  localparam int CONV1_OUT_W  = 24;
  localparam int CONV1_OUT_H  = 24;
  localparam int CONV_OUT_BIT = 12;

  // Pooled map is half the conv map in each dimension (2x2, stride 2)
  localparam int POOL1_OUT_W = CONV1_OUT_W / 2;
  localparam int POOL1_OUT_H = CONV1_OUT_H / 2;

endpackage

// File: rtl/maxpool_lane.sv
// One channel of ReLU + 2x2/stride-2 max pooling: hold register, half-row line buffer, compare.
// Macro MAXPOOL_RELU_EN enables ReLU (unsigned compare); undefined keeps raw signed values.
module maxpool_lane
  import cnn_pkg::*;
#(
  parameter int DATA_BIT = CONV_OUT_BIT,
  parameter int DEPTH    = POOL1_OUT_W,
  parameter int ADDR_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                accept,
  input  logic                col_odd,
  input  logic                row_odd,
  input  logic [ADDR_BIT-1:0] addr,
  input  logic [DATA_BIT-1:0] conv_in,
  output logic [DATA_BIT-1:0] pool_out
);

  logic [DATA_BIT-1:0] r;
  logic [DATA_BIT-1:0] hold;
  logic [DATA_BIT-1:0] pair_max;
  logic [DATA_BIT-1:0] lb_rd;
  logic [DATA_BIT-1:0] linebuf [DEPTH];

`ifdef MAXPOOL_RELU_EN
  assign r = conv_in[DATA_BIT-1] ? '0 : conv_in;

  function automatic logic [DATA_BIT-1:0] pick_max(input logic [DATA_BIT-1:0] a,
                                                   input logic [DATA_BIT-1:0] b);
    return (a > b) ? a : b;
  endfunction
`else
  assign r = conv_in;

  function automatic logic [DATA_BIT-1:0] pick_max(input logic [DATA_BIT-1:0] a,
                                                   input logic [DATA_BIT-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction
`endif

  assign pair_max = pick_max(hold, r);
  assign lb_rd    = linebuf[addr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold     <= '0;
      pool_out <= '0;
    end else if (accept) begin
      if (!col_odd) begin
        hold <= r;
      end else if (row_odd) begin
        pool_out <= pick_max(lb_rd, pair_max);
      end
    end
  end

  // Not reset: every even row rewrites an entry before the odd row reads it
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd) begin
      linebuf[addr] <= pair_max;
    end
  end

endmodule

// File: rtl/maxpool_relu_3ch.sv
// Three-channel ReLU + 2x2 max pooling over a raster conv stream; owns the shared counters.
// Macro MAXPOOL_RELU_EN selects ReLU-enabled lanes (see maxpool_lane).
module maxpool_relu_3ch
  import cnn_pkg::*;
#(
  parameter int WIDTH    = CONV1_OUT_W,
  parameter int HEIGHT   = CONV1_OUT_H,
  parameter int DATA_BIT = CONV_OUT_BIT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [DATA_BIT-1:0] conv_in_1,
  input  logic [DATA_BIT-1:0] conv_in_2,
  input  logic [DATA_BIT-1:0] conv_in_3,
  output logic [DATA_BIT-1:0] pool_out_1,
  output logic [DATA_BIT-1:0] pool_out_2,
  output logic [DATA_BIT-1:0] pool_out_3,
  output logic                valid_out,
  output logic                frame_done
);

  localparam int COL_BIT  = $clog2(WIDTH);
  localparam int ROW_BIT  = $clog2(HEIGHT);
  localparam int ADDR_BIT = COL_BIT - 1;
  localparam logic [COL_BIT-1:0] COL_LAST = COL_BIT'(WIDTH - 1);
  localparam logic [ROW_BIT-1:0] ROW_LAST = ROW_BIT'(HEIGHT - 1);

  logic [COL_BIT-1:0]  col;
  logic [ROW_BIT-1:0]  row;
  logic                col_odd;
  logic                row_odd;
  logic                last_col;
  logic                last_row;
  logic [ADDR_BIT-1:0] addr;

  assign col_odd  = col[0];
  assign row_odd  = row[0];
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);
  assign addr     = col[COL_BIT-1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (valid_in) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Pooled pixel completes on the bottom-right (odd row, odd col) input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= valid_in && col_odd && row_odd;
      frame_done <= valid_in && last_col && last_row;
    end
  end

  maxpool_lane #(
    .DATA_BIT(DATA_BIT),
    .DEPTH   (WIDTH / 2),
    .ADDR_BIT(ADDR_BIT)
  ) u_lane_1 (
    .clk     (clk),
    .rst     (rst),
    .accept  (valid_in),
    .col_odd (col_odd),
    .row_odd (row_odd),
    .addr    (addr),
    .conv_in (conv_in_1),
    .pool_out(pool_out_1)
  );

  maxpool_lane #(
    .DATA_BIT(DATA_BIT),
    .DEPTH   (WIDTH / 2),
    .ADDR_BIT(ADDR_BIT)
  ) u_lane_2 (
    .clk     (clk),
    .rst     (rst),
    .accept  (valid_in),
    .col_odd (col_odd),
    .row_odd (row_odd),
    .addr    (addr),
    .conv_in (conv_in_2),
    .pool_out(pool_out_2)
  );

  maxpool_lane #(
    .DATA_BIT(DATA_BIT),
    .DEPTH   (WIDTH / 2),
    .ADDR_BIT(ADDR_BIT)
  ) u_lane_3 (
    .clk     (clk),
    .rst     (rst),
    .accept  (valid_in),
    .col_odd (col_odd),
    .row_odd (row_odd),
    .addr    (addr),
    .conv_in (conv_in_3),
    .pool_out(pool_out_3)
  );

endmodule
